// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
// Default limits correspond to a 27 MHz reference clock.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PRST    = 3'd0,
        WAIT    = 3'd1,
        STABLE  = 3'd2,
        RELEASE = 3'd3,
        RUN     = 3'd4,
        FAULT   = 3'd5
    } state_t;

    localparam int unsigned DEF_NUM_PLL          = 2;
    localparam int unsigned DEF_SYNC_STAGES      = 2;
    localparam int unsigned DEF_RST_PULSE_CYC    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 27000;
    localparam int unsigned DEF_STABLE_CYC       = 270;
    localparam int unsigned DEF_RELEASE_GAP_CYC  = 8;
    localparam int unsigned DEF_MAX_RETRY        = 3;

    // Width of a counter that must be able to hold values 0..limit.
    function automatic int unsigned cnt_w(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sync_bits.sv
// N-bit, S-stage flop synchroniser for asynchronous level inputs.
module sync_bits #(
    parameter int unsigned N = 1,
    parameter int unsigned S = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);

    logic [S-1:0][N-1:0] r_stage;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int unsigned k = 1; k < S; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_q = r_stage[S-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Supervises NUM_PLL PLLs: pulses their reset, qualifies lock, releases the
// per-domain resets in ascending order, retries on timeout and latches a fault.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned NUM_PLL          = DEF_NUM_PLL,
    parameter int unsigned SYNC_STAGES      = DEF_SYNC_STAGES,
    parameter int unsigned RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int unsigned STABLE_CYC       = DEF_STABLE_CYC,
    parameter int unsigned RELEASE_GAP_CYC  = DEF_RELEASE_GAP_CYC,
    parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY
) (
    input  logic                             clkin,
    input  logic                             reset,
    input  logic [NUM_PLL-1:0]               pll_lock,
    output logic [NUM_PLL-1:0]               pll_reset,
    output logic [NUM_PLL-1:0]               domain_reset,
    output logic                             all_locked,
    output logic                             fault,
    output logic [cnt_w(MAX_RETRY)-1:0]      retry_cnt,
    output logic [7:0]                       loss_cnt
);

    localparam int unsigned PULSE_W = cnt_w(RST_PULSE_CYC);
    localparam int unsigned TMR_W   = cnt_w(LOCK_TIMEOUT_CYC);
    localparam int unsigned STB_W   = cnt_w(STABLE_CYC);
    localparam int unsigned GAP_W   = cnt_w(RELEASE_GAP_CYC);
    localparam int unsigned RETRY_W = cnt_w(MAX_RETRY);
    localparam int unsigned IDX_W   = (NUM_PLL > 1) ? $clog2(NUM_PLL) : 1;

    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE_CYC - 1);
    localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [STB_W-1:0]   STB_LAST   = STB_W'(STABLE_CYC - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(RELEASE_GAP_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'((NUM_PLL > 1) ? NUM_PLL - 2 : 0);

    state_t               r_state, w_state_nxt;
    logic [PULSE_W-1:0]   r_pulse, w_pulse_nxt;
    logic [TMR_W-1:0]     r_timer, w_timer_nxt;
    logic [STB_W-1:0]     r_stable, w_stable_nxt;
    logic [GAP_W-1:0]     r_gap, w_gap_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [RETRY_W-1:0]   r_retry, w_retry_nxt;
    logic [7:0]           r_loss, w_loss_nxt;
    logic [NUM_PLL-1:0]   r_dom, w_dom_nxt;
    logic                 r_al, w_al_nxt;
    logic                 r_pll_rst, w_pll_rst_nxt;
    logic                 r_fault, w_fault_nxt;

    logic [NUM_PLL-1:0]   w_lock_sync;
    logic                 w_lk;
    logic                 w_loss_evt;
    logic                 w_to_evt;

    sync_bits #(
        .N (NUM_PLL),
        .S (SYNC_STAGES)
    ) u_lock_sync (
        .i_clk (clkin),
        .i_rst (reset),
        .i_d   (pll_lock),
        .o_q   (w_lock_sync)
    );

    assign w_lk       = &w_lock_sync;
    assign w_loss_evt = !w_lk && (r_state == RELEASE || r_state == RUN);
    assign w_to_evt   = (r_timer == TMR_LAST) && (r_state == WAIT || r_state == STABLE);

    always_comb begin
        w_state_nxt  = r_state;
        w_pulse_nxt  = r_pulse;
        w_timer_nxt  = r_timer;
        w_stable_nxt = r_stable;
        w_gap_nxt    = r_gap;
        w_idx_nxt    = r_idx;
        w_retry_nxt  = r_retry;
        w_loss_nxt   = r_loss;
        w_dom_nxt    = r_dom;
        w_al_nxt     = r_al;

        if (w_loss_evt) begin
            w_state_nxt = PRST;
            w_pulse_nxt = '0;
            w_timer_nxt = '0;
            w_dom_nxt   = '1;
            w_al_nxt    = 1'b0;
            if (r_loss != 8'hFF) begin
                w_loss_nxt = r_loss + 8'd1;
            end
        end else if (w_to_evt) begin
            // Timeout wins over a stable-count completion in the same cycle.
            w_retry_nxt = r_retry + RETRY_W'(1);
            w_dom_nxt   = '1;
            if (r_retry == RETRY_LAST) begin
                w_state_nxt = FAULT;
            end else begin
                w_state_nxt = PRST;
                w_pulse_nxt = '0;
                w_timer_nxt = '0;
            end
        end else begin
            case (r_state)
                PRST: begin
                    if (r_pulse == PULSE_LAST) begin
                        w_state_nxt = WAIT;
                    end else begin
                        w_pulse_nxt = r_pulse + PULSE_W'(1);
                    end
                end
                WAIT: begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                    if (w_lk) begin
                        w_state_nxt  = STABLE;
                        w_stable_nxt = '0;
                    end
                end
                STABLE: begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                    if (!w_lk) begin
                        w_state_nxt = WAIT;
                    end else if (r_stable == STB_LAST) begin
                        w_dom_nxt    = '1;
                        w_dom_nxt[0] = 1'b0;
                        w_gap_nxt    = '0;
                        w_idx_nxt    = '0;
                        if (NUM_PLL == 1) begin
                            w_state_nxt = RUN;
                            w_al_nxt    = 1'b1;
                            w_retry_nxt = '0;
                        end else begin
                            w_state_nxt = RELEASE;
                        end
                    end else begin
                        w_stable_nxt = r_stable + STB_W'(1);
                    end
                end
                RELEASE: begin
                    // Released domains occupy the low bits, so each step is a shift.
                    if (r_gap == GAP_LAST) begin
                        w_gap_nxt = '0;
                        w_dom_nxt = r_dom << 1;
                        w_idx_nxt = r_idx + IDX_W'(1);
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = RUN;
                            w_al_nxt    = 1'b1;
                            w_retry_nxt = '0;
                        end
                    end else begin
                        w_gap_nxt = r_gap + GAP_W'(1);
                    end
                end
                RUN:     ;
                FAULT:   ;
                default: begin
                    w_state_nxt = PRST;
                    w_pulse_nxt = '0;
                    w_timer_nxt = '0;
                    w_dom_nxt   = '1;
                    w_al_nxt    = 1'b0;
                end
            endcase
        end

        w_pll_rst_nxt = (w_state_nxt == PRST) || (w_state_nxt == FAULT);
        w_fault_nxt   = (w_state_nxt == FAULT);
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_state   <= PRST;
            r_pulse   <= '0;
            r_timer   <= '0;
            r_stable  <= '0;
            r_gap     <= '0;
            r_idx     <= '0;
            r_retry   <= '0;
            r_loss    <= '0;
            r_dom     <= '1;
            r_al      <= 1'b0;
            r_pll_rst <= 1'b1;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pulse   <= w_pulse_nxt;
            r_timer   <= w_timer_nxt;
            r_stable  <= w_stable_nxt;
            r_gap     <= w_gap_nxt;
            r_idx     <= w_idx_nxt;
            r_retry   <= w_retry_nxt;
            r_loss    <= w_loss_nxt;
            r_dom     <= w_dom_nxt;
            r_al      <= w_al_nxt;
            r_pll_rst <= w_pll_rst_nxt;
            r_fault   <= w_fault_nxt;
        end
    end

    assign pll_reset    = {NUM_PLL{r_pll_rst}};
    assign domain_reset = r_dom;
    assign all_locked   = r_al;
    assign fault        = r_fault;
    assign retry_cnt    = r_retry;
    assign loss_cnt     = r_loss;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed output snapshots per cycle,
// a monitor compares them shortly after each clock edge.
module tb_pll_lock_sequencer;

    logic       clkin;
    logic       reset;
    logic [1:0] pll_lock;
    logic [1:0] pll_reset;
    logic [1:0] domain_reset;
    logic       all_locked;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;

    pll_lock_sequencer #(
        .NUM_PLL          (2),
        .SYNC_STAGES      (2),
        .RST_PULSE_CYC    (4),
        .LOCK_TIMEOUT_CYC (100),
        .STABLE_CYC       (10),
        .RELEASE_GAP_CYC  (3),
        .MAX_RETRY        (2)
    ) dut (
        .clkin        (clkin),
        .reset        (reset),
        .pll_lock     (pll_lock),
        .pll_reset    (pll_reset),
        .domain_reset (domain_reset),
        .all_locked   (all_locked),
        .fault        (fault),
        .retry_cnt    (retry_cnt),
        .loss_cnt     (loss_cnt)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    int unsigned tick = 0;
    always @(posedge clkin) tick <= tick + 1;

    typedef struct packed {
        int unsigned cyc;
        logic [15:0] v;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    int unsigned base   = 0;
    int          errors = 0;
    int          checks = 0;

    // Cycle c of a sequence is the interval after the c-th edge, edge 0 being
    // the last edge that samples reset high.
    task automatic expect_at(input string nm, input int unsigned c,
                             input logic [1:0] pr, input logic [1:0] dr,
                             input logic al, input logic f,
                             input logic [1:0] rc, input logic [7:0] lc);
        exp_t e;
        e.cyc = base + c;
        e.v   = {pr, dr, al, f, rc, lc};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (tick < base + c) @(negedge clkin);
    endtask

    task automatic start_seq(input logic [1:0] lk);
        @(negedge clkin);
        reset    = 1'b1;
        pll_lock = lk;
        @(negedge clkin);
        base  = tick;
        reset = 1'b0;
    endtask

    exp_t        m_e;
    string       m_nm;
    logic [15:0] m_got;

    always @(posedge clkin) begin
        #1;
        m_got = {pll_reset, domain_reset, all_locked, fault, retry_cnt, loss_cnt};
        while (exp_q.size() != 0 && exp_q[0].cyc <= tick) begin
            m_e  = exp_q.pop_front();
            m_nm = name_q.pop_front();
            checks++;
            if (m_e.cyc != tick) begin
                errors++;
                $display("FAIL %s: expected at tick %0d but first sampled at tick %0d",
                         m_nm, m_e.cyc, tick);
            end else if (m_got !== m_e.v) begin
                errors++;
                $display("FAIL %s @cyc %0d: got pr=%b dr=%b al=%b f=%b rc=%0d lc=%0d, want pr=%b dr=%b al=%b f=%b rc=%0d lc=%0d",
                         m_nm, tick - base,
                         m_got[15:14], m_got[13:12], m_got[11], m_got[10], m_got[9:8], m_got[7:0],
                         m_e.v[15:14], m_e.v[13:12], m_e.v[11], m_e.v[10], m_e.v[9:8], m_e.v[7:0]);
            end
        end
    end

    int unsigned tk;
    int unsigned lc_b;
    int unsigned lc_a;

    initial begin
        reset    = 1'b1;
        pll_lock = 2'b00;

        // Nominal bring-up followed by a lock loss in RUN and re-lock.
        start_seq(2'b00);
        expect_at("rst_state",     1,  2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at("prst_hold",     3,  2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at("pll_rst_fall",  4,  2'b00, 2'b11, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at("pre_release",   32, 2'b00, 2'b11, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at("rel_dom0",      33, 2'b00, 2'b10, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at("rel_gap",       35, 2'b00, 2'b10, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at("run_entry",     36, 2'b00, 2'b00, 1'b1, 1'b0, 2'd0, 8'd0);
        expect_at("run_lk_low",    52, 2'b00, 2'b00, 1'b1, 1'b0, 2'd0, 8'd0);
        expect_at("loss_react",    53, 2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 8'd1);
        expect_at("loss_prst_end", 56, 2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 8'd1);
        expect_at("loss_wait",     57, 2'b00, 2'b11, 1'b0, 1'b0, 2'd0, 8'd1);
        expect_at("relock_rel",    73, 2'b00, 2'b10, 1'b0, 1'b0, 2'd0, 8'd1);
        expect_at("relock_run",    76, 2'b00, 2'b00, 1'b1, 1'b0, 2'd0, 8'd1);
        wait_cyc(20); pll_lock = 2'b11;
        wait_cyc(50); pll_lock = 2'b10;
        wait_cyc(60); pll_lock = 2'b11;
        wait_cyc(80);

        // One-cycle glitch on lock[1] while in STABLE restarts qualification.
        start_seq(2'b00);
        expect_at("g_rst_state",   1,  2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at("g_no_early",    33, 2'b00, 2'b11, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at("g_pre_release", 41, 2'b00, 2'b11, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at("g_rel_dom0",    42, 2'b00, 2'b10, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at("g_run",         45, 2'b00, 2'b00, 1'b1, 1'b0, 2'd0, 8'd0);
        wait_cyc(20); pll_lock = 2'b11;
        wait_cyc(28); pll_lock = 2'b01;
        wait_cyc(29); pll_lock = 2'b11;
        wait_cyc(50);

        // Locks never rise: two timeouts lead to a sticky fault.
        start_seq(2'b00);
        expect_at("t_rst_state",   1,   2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at("t_pre_timeout", 103, 2'b00, 2'b11, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at("t_retry1",      104, 2'b11, 2'b11, 1'b0, 1'b0, 2'd1, 8'd0);
        expect_at("t_prst_hold",   107, 2'b11, 2'b11, 1'b0, 1'b0, 2'd1, 8'd0);
        expect_at("t_wait2",       108, 2'b00, 2'b11, 1'b0, 1'b0, 2'd1, 8'd0);
        expect_at("t_pre_fault",   207, 2'b00, 2'b11, 1'b0, 1'b0, 2'd1, 8'd0);
        expect_at("t_fault",       208, 2'b11, 2'b11, 1'b0, 1'b1, 2'd2, 8'd0);
        expect_at("t_fault_hold",  300, 2'b11, 2'b11, 1'b0, 1'b1, 2'd2, 8'd0);
        wait_cyc(220); pll_lock = 2'b11;
        wait_cyc(301);

        // Leaves FAULT via reset, takes one loss, then reset lands mid-RELEASE.
        start_seq(2'b00);
        expect_at("r_rst_from_fault", 1,  2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at("r_loss",           43, 2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 8'd1);
        expect_at("r_mid_release",    61, 2'b00, 2'b10, 1'b0, 1'b0, 2'd0, 8'd1);
        expect_at("r_rst_pending",    62, 2'b00, 2'b10, 1'b0, 1'b0, 2'd0, 8'd1);
        expect_at("r_rst_applied",    63, 2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 8'd0);
        wait_cyc(20); pll_lock = 2'b11;
        wait_cyc(40); pll_lock = 2'b10;
        wait_cyc(48); pll_lock = 2'b11;
        wait_cyc(62); reset = 1'b1;
        wait_cyc(64);

        // 300 lock-loss events in RUN, one every 22 cycles: loss_cnt saturates.
        start_seq(2'b11);
        expect_at("s_run0", 18, 2'b00, 2'b00, 1'b1, 1'b0, 2'd0, 8'd0);
        for (int k = 0; k < 300; k++) begin
            if (k == 0 || k == 1 || k == 254 || k == 255 || k == 299) begin
                tk   = 20 + 22 * k;
                lc_b = (k > 255) ? 255 : k;
                lc_a = (k + 1 > 255) ? 255 : k + 1;
                expect_at("s_before_loss", tk + 2, 2'b00, 2'b00, 1'b1, 1'b0, 2'd0, 8'(lc_b));
                expect_at("s_loss",        tk + 3, 2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 8'(lc_a));
            end
        end
        expect_at("s_final_run", 20 + 22 * 299 + 21, 2'b00, 2'b00, 1'b1, 1'b0, 2'd0, 8'd255);
        for (int k = 0; k < 300; k++) begin
            wait_cyc(20 + 22 * k);     pll_lock = 2'b10;
            wait_cyc(20 + 22 * k + 1); pll_lock = 2'b11;
        end
        wait_cyc(20 + 22 * 299 + 25);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clkin);
        while (exp_q.size() != 0) begin
            m_e  = exp_q.pop_front();
            m_nm = name_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never sampled, expected at tick %0d, now %0d", m_nm, m_e.cyc, tick);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
